// File: rtl/vecmul_pkg.sv
// Shared types and defaults for the vecmul front-end sequencer and its result FIFO.
package vecmul_pkg;

   typedef logic [31:0] fp32_t;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } seq_state_e;

   localparam int DEFAULT_TIMEOUT = 32;

endpackage

// File: rtl/vecmul_res_fifo.sv
// Result FIFO with a registered head entry; with VECMUL_SEQ_STATUS_EN each entry
// also carries a timeout-capture flag.
module vecmul_res_fifo
   import vecmul_pkg::*;
#(
   parameter int RES_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  fp32_t                      wdata_i,
`ifdef VECMUL_SEQ_STATUS_EN
   input  logic                       wtout_i,
   output logic                       rtout_o,
`endif
   input  logic                       pop_i,
   output fp32_t                      rdata_o,
   output logic [$clog2(RES_DEPTH):0] count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int AW = $clog2(RES_DEPTH);
   localparam int PW = AW + 1;

   fp32_t         mem_q [RES_DEPTH];
   fp32_t         head_q, head_d;
   logic [PW-1:0] wrPtr_q, rdPtr_q, rdPtr_d;
   logic          doPush, doPop, headIsNew, headFromMem;
`ifdef VECMUL_SEQ_STATUS_EN
   logic          toutMem_q [RES_DEPTH];
   logic          toutHead_q, toutHead_d;
`endif

   assign count_o = wrPtr_q - rdPtr_q;
   assign full_o  = (count_o == PW'(RES_DEPTH));
   assign empty_o = (count_o == '0);
   assign doPush  = push_i && !full_o;
   assign doPop   = pop_i && !empty_o;

   // The head register is loaded with whatever entry will be at the front after this cycle.
   always_comb begin
      rdPtr_d     = rdPtr_q + PW'(doPop);
      headIsNew   = doPush && (wrPtr_q == rdPtr_d);
      headFromMem = (wrPtr_q != rdPtr_d);
      head_d      = head_q;
      if (headIsNew) begin
         head_d = wdata_i;
      end else if (headFromMem) begin
         head_d = mem_q[rdPtr_d[AW-1:0]];
      end
`ifdef VECMUL_SEQ_STATUS_EN
      toutHead_d = toutHead_q;
      if (headIsNew) begin
         toutHead_d = wtout_i;
      end else if (headFromMem) begin
         toutHead_d = toutMem_q[rdPtr_d[AW-1:0]];
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         head_q  <= '0;
         for (int i = 0; i < RES_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
`ifdef VECMUL_SEQ_STATUS_EN
         toutHead_q <= 1'b0;
         for (int i = 0; i < RES_DEPTH; i++) begin
            toutMem_q[i] <= 1'b0;
         end
`endif
      end else begin
         if (doPush) begin
            mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
`ifdef VECMUL_SEQ_STATUS_EN
            toutMem_q[wrPtr_q[AW-1:0]] <= wtout_i;
`endif
            wrPtr_q <= wrPtr_q + PW'(1);
         end
         rdPtr_q <= rdPtr_d;
         head_q  <= head_d;
`ifdef VECMUL_SEQ_STATUS_EN
         toutHead_q <= toutHead_d;
`endif
      end
   end

   assign rdata_o = head_q;
`ifdef VECMUL_SEQ_STATUS_EN
   assign rtout_o = toutHead_q;
`endif

endmodule

// File: rtl/vecmul_seq.sv
// Front-end sequencer for the vecmul dot-product engine: packs operand pairs into
// vectors, runs one vecmul pass per vector, queues results. Option: VECMUL_SEQ_STATUS_EN.
module vecmul_seq
   import vecmul_pkg::*;
#(
   parameter int VSIZE     = 4,
   parameter int RES_DEPTH = 4,
   parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_valid,
   output logic        s_ready,
   input  fp32_t       s_a,
   input  fp32_t       s_b,
   output fp32_t       vm_in1 [VSIZE],
   output fp32_t       vm_in2 [VSIZE],
   output logic        vm_en,
   input  fp32_t       vm_result,
   input  logic        vm_done,
   output logic        m_valid,
   input  logic        m_ready,
`ifdef VECMUL_SEQ_STATUS_EN
   output logic        m_tout,
   output logic [15:0] tout_cnt,
`endif
   output fp32_t       m_data
);

   localparam int ECW   = (VSIZE > 1) ? $clog2(VSIZE) : 1;
   localparam int TMO_W = $clog2(TIMEOUT) + 1;
   localparam int PW    = $clog2(RES_DEPTH) + 1;

   seq_state_e       state_q;
   logic [ECW-1:0]   elemCnt_q;
   logic [TMO_W-1:0] tmoCnt_q;
   logic             sReady_q, vmEn_q;
   fp32_t            vmIn1_q [VSIZE];
   fp32_t            vmIn2_q [VSIZE];
   logic [PW-1:0]    resCount;
   logic             resFull, resEmpty, spaceOk, tmoHit, capture, push;
`ifdef VECMUL_SEQ_STATUS_EN
   logic [15:0]      toutCnt_q;
`endif

   assign spaceOk = (resCount < PW'(RES_DEPTH)) && !resFull;
   assign tmoHit  = (tmoCnt_q == TMO_W'(TIMEOUT - 1));
   assign capture = vm_done || tmoHit;
   assign push    = (state_q == WAIT) && capture;

   // Issue reserves a FIFO slot, so the single push on leaving WAIT can never overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FILL;
         elemCnt_q <= '0;
         tmoCnt_q  <= '0;
         sReady_q  <= 1'b0;
         vmEn_q    <= 1'b0;
         for (int i = 0; i < VSIZE; i++) begin
            vmIn1_q[i] <= '0;
            vmIn2_q[i] <= '0;
         end
`ifdef VECMUL_SEQ_STATUS_EN
         toutCnt_q <= '0;
`endif
      end else begin
         case (state_q)
            FILL: begin
               sReady_q <= 1'b1;
               if (s_valid && sReady_q) begin
                  vmIn1_q[elemCnt_q] <= s_a;
                  vmIn2_q[elemCnt_q] <= s_b;
                  if (elemCnt_q == ECW'(VSIZE - 1)) begin
                     elemCnt_q <= '0;
                     sReady_q  <= 1'b0;
                     state_q   <= ISSUE;
                  end else begin
                     elemCnt_q <= elemCnt_q + ECW'(1);
                  end
               end
            end
            ISSUE: begin
               if (spaceOk) begin
                  vmEn_q   <= 1'b1;
                  tmoCnt_q <= '0;
                  state_q  <= WAIT;
               end
            end
            WAIT: begin
               tmoCnt_q <= tmoCnt_q + TMO_W'(1);
               if (capture) begin
                  vmEn_q   <= 1'b0;
                  sReady_q <= 1'b1;
                  state_q  <= FILL;
               end
`ifdef VECMUL_SEQ_STATUS_EN
               if (capture && !vm_done && (toutCnt_q != 16'hFFFF)) begin
                  toutCnt_q <= toutCnt_q + 16'd1;
               end
`endif
            end
            default: state_q <= FILL;
         endcase
      end
   end

   vecmul_res_fifo #(
      .RES_DEPTH (RES_DEPTH)
   ) uResFifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .wdata_i (vm_result),
`ifdef VECMUL_SEQ_STATUS_EN
      .wtout_i (!vm_done),
      .rtout_o (m_tout),
`endif
      .pop_i   (m_ready),
      .rdata_o (m_data),
      .count_o (resCount),
      .full_o  (resFull),
      .empty_o (resEmpty)
   );

   assign s_ready = sReady_q;
   assign vm_en   = vmEn_q;
   assign vm_in1  = vmIn1_q;
   assign vm_in2  = vmIn2_q;
   assign m_valid = !resEmpty;
`ifdef VECMUL_SEQ_STATUS_EN
   assign tout_cnt = toutCnt_q;
`endif

endmodule

// File: tb/tb_vecmul_seq.sv
// Self-checking bench for vecmul_seq with a behavioural vecmul attached; honours VECMUL_SEQ_STATUS_EN.
module tb_vecmul_seq;
   import vecmul_pkg::*;

   localparam int VSIZE     = 4;
   localparam int RES_DEPTH = 4;
   localparam int TIMEOUT   = 32;
   localparam int VM_LAT    = 3;

   logic  clk = 1'b0;
   logic  rst_n = 1'b1;
   logic  s_valid = 1'b0;
   logic  s_ready;
   fp32_t s_a = '0;
   fp32_t s_b = '0;
   fp32_t vm_in1 [VSIZE];
   fp32_t vm_in2 [VSIZE];
   logic  vm_en;
   fp32_t vm_result;
   logic  vm_done;
   logic  m_valid;
   logic  m_ready = 1'b0;
   fp32_t m_data;
`ifdef VECMUL_SEQ_STATUS_EN
   logic        m_tout;
   logic [15:0] tout_cnt;
`endif

   int    compared = 0;
   int    mismatched = 0;
   fp32_t expQ[$];
   logic  expToutQ[$];
   fp32_t prevExp = '0;
   logic  mReadyEn = 1'b1;
   logic  mReadyRand = 1'b0;
   logic  injDone = 1'b0;

   logic  mdlDone;
   fp32_t mdlResult, mdlPrev;
   int    mdlPipe;
   logic  mdlEnPrev;

   always #5 clk = ~clk;

   vecmul_seq #(
      .VSIZE     (VSIZE),
      .RES_DEPTH (RES_DEPTH),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_a       (s_a),
      .s_b       (s_b),
      .vm_in1    (vm_in1),
      .vm_in2    (vm_in2),
      .vm_en     (vm_en),
      .vm_result (vm_result),
      .vm_done   (vm_done),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
`ifdef VECMUL_SEQ_STATUS_EN
      .m_tout    (m_tout),
      .tout_cnt  (tout_cnt),
`endif
      .m_data    (m_data)
   );

   // Small non-negative integers only, so fp32 encode/decode is exact.
   function automatic fp32_t intToFp32(input int unsigned n);
      int    msb;
      fp32_t r;
      msb = 0;
      if (n == 0) return 32'h0;
      for (int i = 0; i < 24; i++) if (n[i]) msb = i;
      r[31]    = 1'b0;
      r[30:23] = 8'(127 + msb);
      r[22:0]  = 23'((n << (23 - msb)) & 32'h007F_FFFF);
      return r;
   endfunction

   function automatic int unsigned fp32ToInt(input fp32_t x);
      int e;
      logic [31:0] mant;
      if (x == 32'h0) return 0;
      e    = int'(x[30:23]) - 127;
      mant = {8'd0, 1'b1, x[22:0]};
      return mant >> (23 - e);
   endfunction

   function automatic fp32_t mdlDot();
      int unsigned acc;
      acc = 0;
      for (int i = 0; i < VSIZE; i++) acc += fp32ToInt(vm_in1[i]) * fp32ToInt(vm_in2[i]);
      return intToFp32(acc);
   endfunction

   // Behavioural vecmul: result VM_LAT cycles after en rises, done suppressed on a repeated result.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdlDone   <= 1'b0;
         mdlResult <= '0;
         mdlPrev   <= '0;
         mdlPipe   <= 0;
         mdlEnPrev <= 1'b0;
      end else begin
         mdlEnPrev <= vm_en;
         mdlDone   <= 1'b0;
         if (vm_en && !mdlEnPrev) begin
            mdlPipe <= VM_LAT;
         end else if (mdlPipe != 0) begin
            mdlPipe <= mdlPipe - 1;
            if (mdlPipe == 1) begin
               mdlResult <= mdlDot();
               if (mdlDot() != mdlPrev) mdlDone <= 1'b1;
               mdlPrev <= mdlDot();
            end
         end
      end
   end

   assign vm_done   = mdlDone | injDone;
   assign vm_result = mdlResult;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Consumer: picks m_ready for the coming edge and checks any entry about to be popped.
   always @(negedge clk) begin
      m_ready = mReadyEn && (!mReadyRand || ($urandom_range(1, 0) == 1));
      if (rst_n && m_valid && m_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_result", m_data, 32'hDEAD_BEEF);
         end else begin
            checkOutput("m_data", m_data, expQ.pop_front());
`ifdef VECMUL_SEQ_STATUS_EN
            checkOutput("m_tout", 32'(m_tout), 32'(expToutQ.pop_front()));
`else
            void'(expToutQ.pop_front());
`endif
         end
      end
   end

   task automatic sendElem(input fp32_t a, input fp32_t b, input bit randValid);
      int  n;
      bit  done;
      n    = 0;
      done = 0;
      while (!done) begin
         @(negedge clk);
         s_a     = a;
         s_b     = b;
         s_valid = !randValid || ($urandom_range(1, 0) == 1);
         if (s_valid && s_ready) begin
            @(posedge clk);
            #1 s_valid = 1'b0;
            done = 1;
         end else begin
            n++;
            if (n > 400) begin
               checkOutput("s_handshake_bound", 32'd0, 32'd1);
               s_valid = 1'b0;
               done = 1;
            end
         end
      end
   endtask

   task automatic applyStimulus(input fp32_t a [VSIZE], input fp32_t b [VSIZE],
                                input fp32_t expRes, input bit randValid);
      expQ.push_back(expRes);
      expToutQ.push_back(expRes == prevExp);
      prevExp = expRes;
      for (int i = 0; i < VSIZE; i++) sendElem(a[i], b[i], randValid);
   endtask

   task automatic sendRandomVector(input bit randValid);
      fp32_t       a [VSIZE];
      fp32_t       b [VSIZE];
      int unsigned acc;
      acc = 0;
      for (int i = 0; i < VSIZE; i++) begin
         int unsigned x, y;
         x    = $urandom_range(7, 0);
         y    = $urandom_range(7, 0);
         acc += x * y;
         a[i] = intToFp32(x);
         b[i] = intToFp32(y);
      end
      applyStimulus(a, b, intToFp32(acc), randValid);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      #1;
      expQ.delete();
      expToutQ.delete();
      prevExp = '0;
      checkOutput("rst_vm_en", 32'(vm_en), 32'd0);
      checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
      checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
      checkOutput("rst_m_data", m_data, 32'd0);
      checkOutput("rst_vm_in1_0", vm_in1[0], 32'd0);
      checkOutput("rst_vm_in2_last", vm_in2[VSIZE-1], 32'd0);
`ifdef VECMUL_SEQ_STATUS_EN
      checkOutput("rst_tout_cnt", 32'(tout_cnt), 32'd0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 checkOutput("s_ready_first_cycle", 32'(s_ready), 32'd0);
      @(negedge clk);
      checkOutput("s_ready_after_reset", 32'(s_ready), 32'd1);
   endtask

   task automatic waitEnCycles(output int cycles);
      int n;
      n      = 0;
      cycles = 0;
      while (!vm_en && n < 100) begin
         @(negedge clk);
         n++;
      end
      while (vm_en && cycles < 500) begin
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic waitDrain(input string tag);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, 32'(expQ.size()), 32'd0);
      repeat (2) @(negedge clk);
      checkOutput({tag, "_m_valid"}, 32'(m_valid), 32'd0);
   endtask

   initial begin
      fp32_t vA [VSIZE];
      fp32_t vOne [VSIZE];
      fp32_t vTwo [VSIZE];
      int    enCycles;
      int    n;
      vA   = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
      vOne = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
      vTwo = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};

      #2 doReset();

      $display("[TB] directed vector 1,2,3,4 . 1,1,1,1");
      applyStimulus(vA, vOne, 32'h4120_0000, 1'b0);
      @(negedge clk);
      checkOutput("issue_vm_en_low", 32'(vm_en), 32'd0);
      checkOutput("issue_s_ready_low", 32'(s_ready), 32'd0);
      @(negedge clk);
      checkOutput("vm_en_rise", 32'(vm_en), 32'd1);
      checkOutput("vm_in1_hold", vm_in1[2], 32'h4040_0000);
      waitEnCycles(enCycles);
      checkOutput("done_wait_cycles", 32'(enCycles), 32'(VM_LAT + 2));
      checkOutput("s_ready_back", 32'(s_ready), 32'd1);
      waitDrain("drain_first");

      $display("[TB] repeated vector captured by timeout");
      applyStimulus(vA, vOne, 32'h4120_0000, 1'b0);
      waitEnCycles(enCycles);
      checkOutput("timeout_wait_cycles", 32'(enCycles), 32'(TIMEOUT));
`ifdef VECMUL_SEQ_STATUS_EN
      checkOutput("tout_cnt_one", 32'(tout_cnt), 32'd1);
`endif
      waitDrain("drain_timeout");

      $display("[TB] backpressure with RES_DEPTH+1 vectors");
      mReadyEn = 1'b0;
      for (int v = 0; v < RES_DEPTH + 1; v++) sendRandomVector(1'b0);
      repeat (6) @(negedge clk);
      checkOutput("park_vm_en", 32'(vm_en), 32'd0);
      checkOutput("park_s_ready", 32'(s_ready), 32'd0);
      checkOutput("park_m_valid", 32'(m_valid), 32'd1);
      checkOutput("park_head", m_data, expQ[0]);
      repeat (3) @(negedge clk);
      checkOutput("park_head_stable", m_data, expQ[0]);
      mReadyEn = 1'b1;
      waitDrain("drain_backpressure");

      $display("[TB] random s_valid with b = 2.0");
      applyStimulus(vOne, vTwo, 32'h4100_0000, 1'b1);
      waitDrain("drain_rand_valid");

      $display("[TB] reset during WAIT");
      applyStimulus(vTwo, vA, 32'h41A0_0000, 1'b0);
      n = 0;
      while (!vm_en && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("wait_reached", 32'(vm_en), 32'd1);
      @(posedge clk);
      #2 doReset();

      $display("[TB] reset after partial fill");
      sendElem(32'h40A0_0000, 32'h40E0_0000, 1'b0);
      sendElem(32'h40A0_0000, 32'h40E0_0000, 1'b0);
      #2 doReset();
      applyStimulus(vA, vOne, 32'h4120_0000, 1'b0);
      waitDrain("drain_after_partial");

      $display("[TB] stray vm_done during FILL");
      @(negedge clk);
      injDone = 1'b1;
      @(negedge clk);
      injDone = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("stray_done_m_valid", 32'(m_valid), 32'd0);
      checkOutput("stray_done_s_ready", 32'(s_ready), 32'd1);

      $display("[TB] randomized traffic");
      mReadyRand = 1'b1;
      for (int v = 0; v < 20; v++) sendRandomVector($urandom_range(1, 0) == 1);
      mReadyRand = 1'b0;
      waitDrain("drain_random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog");
   end

endmodule
